// File: rtl/abs_sim_pipe.sv
// abs_sim_pipe: two-stage per-lane similarity score pipeline.
// Define ABS_SIM_ACC_EN to build the window accumulator FSM.
module abs_sim_pipe #(
  parameter  int W       = 8,
  parameter  int LANES   = 4,
  parameter  int ACC_LEN = 16,
  localparam int ACC_W   = W + $clog2(LANES)
                             + $clog2(ACC_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*LANES-1:0] op1,
  input  logic [W*LANES-1:0] op2,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*LANES-1:0] res,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_valid
);

  logic               adv;
  logic               s1_valid;
  logic [W*LANES-1:0] s1_a;
  logic [W*LANES-1:0] s1_b;
  logic [W*LANES-1:0] score;
  logic [W-1:0]       la;
  logic [W-1:0]       lb;
  logic [W-1:0]       ld;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: capture operands; hold contents while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= op1;
        s1_b <= op2;
      end
    end
  end

  // Per-lane score: all-ones minus absolute difference.
  always_comb begin
    score = '0;
    la    = '0;
    lb    = '0;
    ld    = '0;
    for (int k = 0; k < LANES; k++) begin
      la = s1_a[k*W +: W];
      lb = s1_b[k*W +: W];
      ld = (la >= lb) ? la - lb : lb - la;
      score[k*W +: W] = {W{1'b1}} - ld;
    end
  end

  // Stage 2: register score; bubbles leave res untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res <= score;
      end
    end
  end

`ifdef ABS_SIM_ACC_EN

  localparam int CW = $clog2(ACC_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic             deliver;
  logic [ACC_W-1:0] beat_sum;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc_r;
  logic             acc_valid_r;

  assign deliver   = out_valid && out_ready;
  assign acc       = acc_r;
  assign acc_valid = acc_valid_r;

  // Sum of all lane scores of the beat on the output.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + ACC_W'(res[k*W +: W]);
    end
  end

  // Window FSM: accumulate deliveries, publish on the last one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      sum         <= '0;
      cnt         <= '0;
      acc_r       <= '0;
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mode) begin
            state <= ACCUM;
            sum   <= deliver ? beat_sum : '0;
            cnt   <= deliver ? CW'(1) : '0;
          end else begin
            sum <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          if (!mode) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
          end else if (deliver) begin
            if (cnt == CW'(ACC_LEN - 1)) begin
              state       <= DONE;
              acc_r       <= sum + beat_sum;
              acc_valid_r <= 1'b1;
              sum         <= '0;
              cnt         <= '0;
            end else begin
              sum <= sum + beat_sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state <= mode ? ACCUM : IDLE;
          if (mode && deliver) begin
            sum <= beat_sum;
            cnt <= CW'(1);
          end else begin
            sum <= '0;
            cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`else

  logic unused_mode;

  assign unused_mode = mode;
  assign acc         = '0;
  assign acc_valid   = 1'b0;

`endif

endmodule

// File: tb/tb_abs_sim_pipe.sv
// tb_abs_sim_pipe: random + directed bench with a
// queue scoreboard and a window-sum reference model.
module tb_abs_sim_pipe;

  localparam int W       = 8;
  localparam int LANES   = 4;
  localparam int ACC_LEN = 16;
  localparam int ACC_W   = 14;
  localparam int DW      = W * LANES;
`ifdef ABS_SIM_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    op1;
  logic [DW-1:0]    op2;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    res;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;

  abs_sim_pipe #(
    .W(W),
    .LANES(LANES),
    .ACC_LEN(ACC_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op1(op1),
    .op2(op2),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res(res),
    .acc(acc),
    .acc_valid(acc_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  int win_cnt;
  int win_sum;
  int exp_acc;
  bit exp_av;
  int n_pulse;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] score(
      input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int x, y, d;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = int'(a[k*W +: W]);
      y = int'(b[k*W +: W]);
      d = (x > y) ? x - y : y - x;
      r[k*W +: W] = W'(255 - d);
    end
    return r;
  endfunction

  function automatic int lane_sum(input logic [DW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < LANES; k++) s += int'(v[k*W +: W]);
    return s;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    win_cnt = 0;
    win_sum = 0;
    exp_acc = 0;
    exp_av  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mode      = 1'b1;
    op1       = rnd();
    op2       = rnd();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_res", res, '0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_acc", acc, '0);
      chk("rst_av", acc_valid, 1'b0);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1'b1);
    clear_model();
  endtask

  // One cycle: drive at negedge, check, then predict the next edge.
  task automatic step(input bit iv,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input bit ordy,
                      input bit md);
    bit dlv;
    int bs;
    bit nxt;
    @(negedge clk);
    in_valid  = iv;
    op1       = a;
    op2       = b;
    out_ready = ordy;
    mode      = md;
    #1;
    chk("acc", acc, ACC_ON ? exp_acc : 0);
    chk("acc_valid", acc_valid, ACC_ON ? exp_av : 1'b0);
    if (acc_valid) n_pulse++;
    chk("in_ready", in_ready, !out_valid || ordy);
    dlv = 1'b0;
    bs  = 0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_ov", out_valid, 1'b0);
      end else begin
        chk("res", res, exp_q[0]);
        if (ordy) begin
          dlv = 1'b1;
          bs  = lane_sum(exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
    if (iv && in_ready) exp_q.push_back(score(a, b));
    nxt = 1'b0;
    if (exp_av) begin
      win_cnt = (md && dlv) ? 1 : 0;
      win_sum = (md && dlv) ? bs : 0;
    end else if (!md) begin
      win_cnt = 0;
      win_sum = 0;
    end else if (dlv) begin
      win_cnt++;
      win_sum += bs;
      if (win_cnt == ACC_LEN) begin
        nxt     = 1'b1;
        exp_acc = win_sum;
        win_cnt = 0;
        win_sum = 0;
      end
    end
    exp_av = nxt;
  endtask

  task automatic drain(input bit md);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, rnd(), rnd(), 1'b1, md);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  logic [DW-1:0] held;
  logic [DW-1:0] v;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    op1       = '0;
    op2       = '0;
    n_pulse   = 0;
    clear_model();
    do_reset();

    // Arithmetic: lanes (200,50) (50,200) (77,77) (0,255).
    step(1'b1, {8'd0, 8'd77, 8'd50, 8'd200},
         {8'd255, 8'd77, 8'd200, 8'd50}, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("arith_ov", out_valid, 1'b1);
    chk("arith_res", res, {8'd0, 8'd255, 8'd105, 8'd105});
    drain(1'b0);

    // Backpressure: 3 beats then 5 stalled cycles.
    repeat (3) step(1'b1, rnd(), rnd(), 1'b1, 1'b0);
    step(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    held = res;
    repeat (4) begin
      step(1'b1, rnd(), rnd(), 1'b0, 1'b0);
      chk("bp_hold", res, held);
      chk("bp_rdy", in_ready, 1'b0);
    end
    drain(1'b0);

    // Accumulate: 16 identical-operand beats.
    n_pulse = 0;
    repeat (ACC_LEN) begin
      v = rnd();
      step(1'b1, v, v, 1'b1, 1'b1);
    end
    repeat (4) step(1'b0, '0, '0, 1'b1, 1'b1);
    chk("acc_pulses", n_pulse, ACC_ON ? 1 : 0);
    chk("acc_win", acc, ACC_ON ? 16320 : 0);
    repeat (3) begin
      v = rnd();
      step(1'b1, v, v, 1'b1, 1'b1);
    end
    drain(1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Abort after 5 deliveries.
    n_pulse = 0;
    repeat (5) step(1'b1, rnd(), rnd(), 1'b1, 1'b1);
    drain(1'b1);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("abort_pulses", n_pulse, 0);
    chk("abort_acc", acc, ACC_ON ? 16320 : 0);

    // Reset after 9 deliveries.
    repeat (9) step(1'b1, rnd(), rnd(), 1'b1, 1'b1);
    drain(1'b1);
    do_reset();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("mid_rst_acc", acc, '0);

    // Random traffic with occasional mode flips.
    mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) mode = !mode;
      step($urandom_range(99) < 75, rnd(), rnd(),
           $urandom_range(99) < 80, mode);
    end
    drain(mode);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
